// File: rtl/gobou_ctrl_mac_pipe.sv
// rtl/gobou_ctrl_mac_pipe.sv - control sequencer for the gobou MAC/accumulator datapath
module gobou_ctrl_mac_pipe #(
    parameter int MACLAT = 2,
    parameter int CNTWID = 16
) (
    input  logic              clk,
    input  logic              xrst,
    input  logic              in_begin,
    input  logic              in_valid,
    input  logic              in_end,
    input  logic              bias_en,
    input  logic              err_clr,
    output logic              accum_we,
    output logic              accum_first,
    output logic              accum_bias,
    output logic              mac_oe,
    output logic              accum_rst,
    output logic              out_begin,
    output logic              out_valid,
    output logic              out_end,
    output logic              busy,
    output logic [CNTWID-1:0] term_cnt,
    output logic              err
);
    localparam int                DCW        = $clog2(MACLAT + 1);
    localparam logic [DCW-1:0]    DRAIN_LOAD = DCW'(MACLAT);
    localparam logic [CNTWID-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, EMIT} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DCW-1:0]    r_drain;
    logic [DCW-1:0]    w_drain_nxt;
    logic [MACLAT-1:0] r_dly_valid;
    logic [MACLAT-1:0] r_dly_first;
    logic [MACLAT-1:0] r_dly_bias;
    logic              r_mac_oe;
    logic              r_post;
    logic              r_busy;
    logic              r_err;
    logic [CNTWID-1:0] r_term_cnt;
    logic              w_accept;
    logic              w_first;
    logic              w_proto_err;

    // Next-state decode: classifies each cycle as accepted term, ignored, or protocol error
    always_comb begin
        w_state_nxt = r_state;
        w_drain_nxt = r_drain;
        w_accept    = 1'b0;
        w_first     = 1'b0;
        w_proto_err = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_begin && in_valid) begin
                    w_accept    = 1'b1;
                    w_first     = 1'b1;
                    w_drain_nxt = DRAIN_LOAD;
                    w_state_nxt = in_end ? DRAIN : ACCUM;
                end else if (in_begin || in_valid || in_end) begin
                    w_proto_err = 1'b1;
                end
            end
            ACCUM: begin
                // A stray begin poisons the whole cycle, so its term and end are dropped too
                if (in_begin) begin
                    w_proto_err = 1'b1;
                end else begin
                    w_accept = in_valid;
                    if (in_end) begin
                        w_drain_nxt = DRAIN_LOAD;
                        w_state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The drain keeps counting through a stray begin so product timing is unaffected
                w_proto_err = in_begin;
                if (r_drain == DCW'(1)) begin
                    w_state_nxt = EMIT;
                end else begin
                    w_drain_nxt = r_drain - DCW'(1);
                end
            end
            EMIT: begin
                w_proto_err = in_begin;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register and drain down-counter
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_state <= IDLE;
            r_drain <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_drain <= w_drain_nxt;
        end
    end

    // Multiplier-latency delay line carrying {valid, first, bias} per accepted term
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_dly_valid <= '0;
            r_dly_first <= '0;
            r_dly_bias  <= '0;
        end else begin
            r_dly_valid[0] <= w_accept;
            r_dly_first[0] <= w_first;
            r_dly_bias[0]  <= w_first & bias_en;
            for (int i = 1; i < MACLAT; i++) begin
                r_dly_valid[i] <= r_dly_valid[i-1];
                r_dly_first[i] <= r_dly_first[i-1];
                r_dly_bias[i]  <= r_dly_bias[i-1];
            end
        end
    end

    // Registered status and result strobes; accum_rst and out_* trail mac_oe by one cycle
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_busy   <= 1'b0;
            r_mac_oe <= 1'b0;
            r_post   <= 1'b0;
        end else begin
            r_busy   <= (w_state_nxt != IDLE);
            r_mac_oe <= (w_state_nxt == EMIT);
            r_post   <= r_mac_oe;
        end
    end

    // Term counter: restarts at 1 on begin, saturates, holds between products
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_term_cnt <= '0;
        end else if (w_accept) begin
            if (w_first) begin
                r_term_cnt <= CNTWID'(1);
            end else if (r_term_cnt != CNT_MAX) begin
                r_term_cnt <= r_term_cnt + CNTWID'(1);
            end
        end
    end

    // Sticky protocol error; a new error outranks a same-cycle clear
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_err <= 1'b0;
        end else if (w_proto_err) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign accum_we    = r_dly_valid[MACLAT-1];
    assign accum_first = r_dly_first[MACLAT-1];
    assign accum_bias  = r_dly_bias[MACLAT-1];
    assign mac_oe      = r_mac_oe;
    assign accum_rst   = r_post;
    assign out_begin   = r_post;
    assign out_valid   = r_post;
    assign out_end     = r_post;
    assign busy        = r_busy;
    assign term_cnt    = r_term_cnt;
    assign err         = r_err;
endmodule

// File: tb/tb_gobou_ctrl_mac_pipe.sv
// tb/tb_gobou_ctrl_mac_pipe.sv - self-checking bench for gobou_ctrl_mac_pipe
module tb_gobou_ctrl_mac_pipe;
    localparam int NMAX = 128;
    localparam int L0 = 2;
    localparam int W0 = 16;
    localparam int L1 = 3;
    localparam int W1 = 2;

    logic clk = 1'b0;
    logic xrst = 1'b0;
    logic in_begin = 1'b0;
    logic in_valid = 1'b0;
    logic in_end = 1'b0;
    logic bias_en = 1'b0;
    logic err_clr = 1'b0;

    // packed outputs: {err, busy, out_end, out_valid, out_begin, accum_rst, mac_oe, bias, first, we}
    wire [9:0]  o0;
    wire [9:0]  o1;
    wire [15:0] cnt0;
    wire [1:0]  cnt1;

    int n_tests = 0;
    int n_fail = 0;

    bit s_beg[NMAX];
    bit s_val[NMAX];
    bit s_end[NMAX];
    bit s_bias[NMAX];
    bit s_clr[NMAX];
    int n_cyc;
    logic [9:0]  exp_v[2][NMAX];
    logic [9:0]  obs_v[2][NMAX];
    logic [15:0] exp_cnt[2][NMAX];
    logic [15:0] obs_cnt[2][NMAX];

    always #5 clk = ~clk;

    gobou_ctrl_mac_pipe #(.MACLAT(L0), .CNTWID(W0)) u_dut0 (
        .clk(clk), .xrst(xrst), .in_begin(in_begin), .in_valid(in_valid), .in_end(in_end),
        .bias_en(bias_en), .err_clr(err_clr),
        .accum_we(o0[0]), .accum_first(o0[1]), .accum_bias(o0[2]), .mac_oe(o0[3]),
        .accum_rst(o0[4]), .out_begin(o0[5]), .out_valid(o0[6]), .out_end(o0[7]),
        .busy(o0[8]), .term_cnt(cnt0), .err(o0[9])
    );

    gobou_ctrl_mac_pipe #(.MACLAT(L1), .CNTWID(W1)) u_dut1 (
        .clk(clk), .xrst(xrst), .in_begin(in_begin), .in_valid(in_valid), .in_end(in_end),
        .bias_en(bias_en), .err_clr(err_clr),
        .accum_we(o1[0]), .accum_first(o1[1]), .accum_bias(o1[2]), .mac_oe(o1[3]),
        .accum_rst(o1[4]), .out_begin(o1[5]), .out_valid(o1[6]), .out_end(o1[7]),
        .busy(o1[8]), .term_cnt(cnt1), .err(o1[9])
    );

    task automatic clear_stim();
        for (int c = 0; c < NMAX; c++) begin
            s_beg[c] = 0; s_val[c] = 0; s_end[c] = 0; s_bias[c] = 0; s_clr[c] = 0;
        end
    endtask

    function automatic void mark(int k, int idx, logic [9:0] m);
        if (idx < n_cyc) exp_v[k][idx] = exp_v[k][idx] | m;
    endfunction

    // Reference: products as begin/term/end events, outputs placed at fixed offsets from them
    task automatic model(input int k, input int lat, input int w);
        int cnt, b, free_at, cmax;
        bit open, err, bad, close;
        cnt = 0; b = 0; free_at = 0; open = 0; err = 0;
        cmax = (1 << w) - 1;
        for (int c = 0; c < NMAX; c++) begin
            exp_v[k][c] = '0;
            exp_cnt[k][c] = '0;
        end
        for (int c = 0; c < n_cyc; c++) begin
            bad = 0; close = 0;
            if (!open && c >= free_at) begin
                if (s_beg[c] && s_val[c]) begin
                    b = c; cnt = 1; open = 1; close = s_end[c];
                    mark(k, c + lat, s_bias[c] ? 10'h007 : 10'h003);
                end else if (s_beg[c] || s_val[c] || s_end[c]) begin
                    bad = 1;
                end
            end else if (s_beg[c]) begin
                bad = 1;
            end else if (open) begin
                if (s_val[c]) begin
                    mark(k, c + lat, 10'h001);
                    if (cnt < cmax) cnt++;
                end
                close = s_end[c];
            end
            if (close) begin
                open = 0;
                free_at = c + lat + 2;
                mark(k, c + lat + 1, 10'h008);
                mark(k, c + lat + 2, 10'h0F0);
                for (int i = b + 1; i <= c + lat + 1; i++) mark(k, i, 10'h100);
            end
            err = bad ? 1'b1 : (s_clr[c] ? 1'b0 : err);
            if (c + 1 < n_cyc) begin
                exp_cnt[k][c+1] = 16'(cnt);
                if (err) mark(k, c + 1, 10'h200);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        xrst = 0;
        in_begin = 0; in_valid = 0; in_end = 0; bias_en = 0; err_clr = 0;
        repeat (2) @(negedge clk);
        xrst = 1;
    endtask

    // Cycle c: observe registered outputs just after its edge, then present its inputs
    task automatic run_stim();
        model(0, L0, W0);
        model(1, L1, W1);
        for (int c = 0; c < n_cyc; c++) begin
            @(posedge clk);
            #1;
            obs_v[0][c] = o0;
            obs_v[1][c] = o1;
            obs_cnt[0][c] = cnt0;
            obs_cnt[1][c] = 16'(cnt1);
            in_begin = s_beg[c]; in_valid = s_val[c]; in_end = s_end[c];
            bias_en = s_bias[c]; err_clr = s_clr[c];
        end
        in_begin = 0; in_valid = 0; in_end = 0; bias_en = 0; err_clr = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        xrst = 1;
        in_valid = 1;
        @(negedge clk);
        in_begin = 1;
        @(negedge clk);
        in_begin = 0; in_valid = 0;
        @(posedge clk);
        #1;
        n_tests++;
        if (o0[9] !== 1'b1 || o0[8] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_precond: err/busy got %b%b, expected 11", o0[9], o0[8]);
        end
        xrst = 0;
        #1;
        n_tests++;
        if (o0 !== 10'h000 || o1 !== 10'h000 || cnt0 !== 16'd0 || cnt1 !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %b %b cnt %0d %0d, expected all zero", o0, o1, cnt0, cnt1);
        end
    endtask

    task automatic test_basic();
        logic [9:0] want;
        do_reset();
        clear_stim();
        s_beg[0] = 1; s_val[0] = 1; s_val[1] = 1; s_val[2] = 1; s_val[3] = 1; s_end[3] = 1;
        n_cyc = 12;
        run_stim();
        for (int c = 0; c < n_cyc; c++) begin
            want = '0;
            want[0] = (c >= 2 && c <= 5);
            want[1] = (c == 2);
            want[3] = (c == 6);
            want[7:4] = (c == 7) ? 4'hF : 4'h0;
            want[8] = (c >= 1 && c <= 6);
            n_tests++;
            if (obs_v[0][c] !== want) begin
                n_fail++;
                $display("FAIL basic_fixed cycle %0d: got %b, expected %b", c, obs_v[0][c], want);
            end
        end
        n_tests++;
        if (obs_cnt[0][n_cyc-1] !== 16'd4) begin
            n_fail++;
            $display("FAIL basic_term_cnt: got %0d, expected 4", obs_cnt[0][n_cyc-1]);
        end
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < n_cyc; c++) begin
                n_tests++;
                if (obs_v[k][c] !== exp_v[k][c] || obs_cnt[k][c] !== exp_cnt[k][c]) begin
                    n_fail++;
                    $display("FAIL basic_trace dut%0d cycle %0d: got %b cnt %0d, expected %b cnt %0d",
                             k, c, obs_v[k][c], obs_cnt[k][c], exp_v[k][c], exp_cnt[k][c]);
                end
            end
    endtask

    task automatic test_single();
        logic [9:0] want;
        do_reset();
        clear_stim();
        s_beg[0] = 1; s_val[0] = 1; s_end[0] = 1;
        n_cyc = 8;
        run_stim();
        for (int c = 0; c < n_cyc; c++) begin
            want = '0;
            want[1:0] = (c == 2) ? 2'b11 : 2'b00;
            want[3] = (c == 3);
            want[7:4] = (c == 4) ? 4'hF : 4'h0;
            want[8] = (c >= 1 && c <= 3);
            n_tests++;
            if (obs_v[0][c] !== want || obs_cnt[0][c] !== ((c >= 1) ? 16'd1 : 16'd0)) begin
                n_fail++;
                $display("FAIL single_fixed cycle %0d: got %b cnt %0d, expected %b", c, obs_v[0][c], obs_cnt[0][c], want);
            end
        end
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < n_cyc; c++) begin
                n_tests++;
                if (obs_v[k][c] !== exp_v[k][c] || obs_cnt[k][c] !== exp_cnt[k][c]) begin
                    n_fail++;
                    $display("FAIL single_trace dut%0d cycle %0d: got %b cnt %0d, expected %b cnt %0d",
                             k, c, obs_v[k][c], obs_cnt[k][c], exp_v[k][c], exp_cnt[k][c]);
                end
            end
    endtask

    task automatic test_bias_bubbles();
        do_reset();
        clear_stim();
        s_beg[0] = 1; s_val[0] = 1; s_bias[0] = 1;
        s_val[2] = 1; s_bias[2] = 1; s_val[4] = 1; s_val[5] = 1; s_end[5] = 1;
        n_cyc = 14;
        run_stim();
        n_tests++;
        if (obs_v[0][2][2:0] !== 3'b111 || obs_v[0][3][0] !== 1'b0 || obs_v[0][5][0] !== 1'b0
            || obs_v[0][4][2] !== 1'b0 || obs_cnt[0][n_cyc-1] !== 16'd4) begin
            n_fail++;
            $display("FAIL bias_fixed: c2 %b c3 %b c4 %b c5 %b cnt %0d, expected 111/0/0/0 cnt 4",
                     obs_v[0][2][2:0], obs_v[0][3][0], obs_v[0][4][2], obs_v[0][5][0], obs_cnt[0][n_cyc-1]);
        end
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < n_cyc; c++) begin
                n_tests++;
                if (obs_v[k][c] !== exp_v[k][c] || obs_cnt[k][c] !== exp_cnt[k][c]) begin
                    n_fail++;
                    $display("FAIL bias_trace dut%0d cycle %0d: got %b cnt %0d, expected %b cnt %0d",
                             k, c, obs_v[k][c], obs_cnt[k][c], exp_v[k][c], exp_cnt[k][c]);
                end
            end
    endtask

    task automatic test_errors();
        do_reset();
        clear_stim();
        s_val[0] = 1;
        s_beg[2] = 1; s_val[2] = 1; s_val[3] = 1; s_end[4] = 1;
        s_beg[5] = 1; s_val[5] = 1;
        s_beg[6] = 1; s_clr[6] = 1;
        s_clr[9] = 1;
        s_end[12] = 1;
        n_cyc = 18;
        run_stim();
        n_tests++;
        if (obs_v[0][1][9] !== 1'b1 || obs_v[0][7][9] !== 1'b1 || obs_v[0][10][9] !== 1'b0
            || obs_v[0][13][9] !== 1'b1 || obs_v[0][7][3] !== 1'b1 || obs_v[0][2][0] !== 1'b0) begin
            n_fail++;
            $display("FAIL errors_fixed: err c1 %b c7 %b c10 %b c13 %b mac_oe c7 %b we c2 %b, expected 1 1 0 1 1 0",
                     obs_v[0][1][9], obs_v[0][7][9], obs_v[0][10][9], obs_v[0][13][9], obs_v[0][7][3], obs_v[0][2][0]);
        end
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < n_cyc; c++) begin
                n_tests++;
                if (obs_v[k][c] !== exp_v[k][c] || obs_cnt[k][c] !== exp_cnt[k][c]) begin
                    n_fail++;
                    $display("FAIL errors_trace dut%0d cycle %0d: got %b cnt %0d, expected %b cnt %0d",
                             k, c, obs_v[k][c], obs_cnt[k][c], exp_v[k][c], exp_cnt[k][c]);
                end
            end
    endtask

    task automatic test_back_to_back();
        do_reset();
        clear_stim();
        s_beg[0] = 1; s_val[0] = 1; s_val[1] = 1; s_val[2] = 1; s_val[3] = 1; s_end[3] = 1;
        s_beg[6] = 1; s_val[6] = 1;
        s_beg[7] = 1; s_val[7] = 1; s_end[7] = 1;
        n_cyc = 14;
        run_stim();
        n_tests++;
        if (obs_v[0][7][9] !== 1'b1 || obs_v[0][8][0] !== 1'b0 || obs_v[0][9][1:0] !== 2'b11
            || obs_v[0][10][3] !== 1'b1 || obs_cnt[0][8] !== 16'd1) begin
            n_fail++;
            $display("FAIL b2b_fixed: err c7 %b we c8 %b first/we c9 %b mac_oe c10 %b cnt c8 %0d, expected 1 0 11 1 1",
                     obs_v[0][7][9], obs_v[0][8][0], obs_v[0][9][1:0], obs_v[0][10][3], obs_cnt[0][8]);
        end
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < n_cyc; c++) begin
                n_tests++;
                if (obs_v[k][c] !== exp_v[k][c] || obs_cnt[k][c] !== exp_cnt[k][c]) begin
                    n_fail++;
                    $display("FAIL b2b_trace dut%0d cycle %0d: got %b cnt %0d, expected %b cnt %0d",
                             k, c, obs_v[k][c], obs_cnt[k][c], exp_v[k][c], exp_cnt[k][c]);
                end
            end
    endtask

    task automatic test_async_reset();
        do_reset();
        @(posedge clk); #1;
        in_begin = 1; in_valid = 1;
        @(posedge clk); #1;
        in_begin = 0; in_end = 1;
        @(posedge clk); #1;
        in_valid = 0; in_end = 0;
        @(posedge clk); #1;
        n_tests++;
        if (o0[8] !== 1'b1 || o1[8] !== 1'b1 || o0[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_precond: busy %b %b we %b, expected 1 1 1", o0[8], o1[8], o0[0]);
        end
        xrst = 0;
        #1;
        n_tests++;
        if (o0 !== 10'h000 || o1 !== 10'h000 || cnt0 !== 16'd0 || cnt1 !== 2'd0) begin
            n_fail++;
            $display("FAIL areset_now: got %b %b cnt %0d %0d, expected all zero", o0, o1, cnt0, cnt1);
        end
        @(negedge clk);
        xrst = 1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            n_tests++;
            if (o0 !== 10'h000 || o1 !== 10'h000) begin
                n_fail++;
                $display("FAIL areset_after cycle %0d: got %b %b, expected all zero", c, o0, o1);
            end
        end
    endtask

    task automatic test_random();
        int c, gap, mid;
        for (int it = 0; it < 16; it++) begin
            do_reset();
            clear_stim();
            c = 0;
            while (c < NMAX - 24) begin
                gap = $urandom_range(6, 0);
                for (int g = 0; g < gap; g++) begin
                    s_val[c] = ($urandom_range(7, 0) == 0);
                    s_clr[c] = ($urandom_range(3, 0) == 0);
                    c++;
                end
                s_beg[c] = 1; s_val[c] = 1;
                if ($urandom_range(4, 0) == 0) begin
                    s_end[c] = 1;
                end else begin
                    mid = $urandom_range(7, 0);
                    for (int t = 0; t < mid; t++) begin
                        c++;
                        s_val[c] = ($urandom_range(3, 0) != 0);
                    end
                    c++;
                    s_end[c] = 1;
                    s_val[c] = $urandom_range(1, 0);
                end
                c += 4;
            end
            for (int i = 0; i < NMAX; i++) s_bias[i] = $urandom_range(1, 0);
            n_cyc = c + 6;
            run_stim();
            for (int k = 0; k < 2; k++)
                for (int cc = 0; cc < n_cyc; cc++) begin
                    n_tests++;
                    if (obs_v[k][cc] !== exp_v[k][cc] || obs_cnt[k][cc] !== exp_cnt[k][cc]) begin
                        n_fail++;
                        $display("FAIL random_trace it%0d dut%0d cycle %0d: got %b cnt %0d, expected %b cnt %0d",
                                 it, k, cc, obs_v[k][cc], obs_cnt[k][cc], exp_v[k][cc], exp_cnt[k][cc]);
                    end
                end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_bias_bubbles();
        test_errors();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
